// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared framebuffer geometry, types and address helper
package vga_pkg;
  localparam int SCREEN_W     = 320;
  localparam int SCREEN_H     = 240;
  localparam int FB_ADDR_W    = 17;
  localparam int FB_WORDS     = 76800;
  localparam int COLOR_W_DFLT = 3;

  typedef logic [COLOR_W_DFLT-1:0] color_t;
  typedef logic [FB_ADDR_W-1:0]    fb_addr_t;

  typedef struct packed {
    fb_addr_t addr;
    color_t   color;
  } pix_entry_t;

  typedef enum logic {ST_RUN, ST_CLEAR} state_t;

  // y*320 + x as y*256 + y*64 + x; the 17-bit sum cannot overflow for in-range inputs
  function automatic fb_addr_t fb_addr(input logic [8:0] x, input logic [7:0] y);
    return {1'b0, y, 8'b0} + {3'b0, y, 6'b0} + {8'b0, x};
  endfunction
endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous register-array FIFO for queued pixel writes
module pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 20
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    full     = (count_q == (AW+1)'(DEPTH));
    empty    = (count_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    rdata    = mem_q[rd_ptr_q];
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/pixel_write_queue.sv
// rtl/pixel_write_queue.sv - pixel stream to framebuffer write port with full-screen clear
module pixel_write_queue import vga_pkg::*; #(
  parameter int FIFO_DEPTH = 8,
  parameter int COLOR_W    = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 draw,
  input  logic [8:0]           x_in,
  input  logic [7:0]           y_in,
  input  logic [COLOR_W-1:0]   color_in,
  output logic                 in_ready,
  input  logic                 clear_start,
  input  logic [COLOR_W-1:0]   bg_color,
  output logic                 clear_done,
  output logic                 busy,
  output logic                 overflow,
  output logic                 clipped,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [FB_ADDR_W-1:0] wr_addr,
  output logic [COLOR_W-1:0]   wr_data
);
  localparam int EW = FB_ADDR_W + COLOR_W;

  logic               in_range, accept, bypass, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic               load, hs;
  logic [EW-1:0]      fifo_rdata;
  fb_addr_t           pix_addr;
  state_t             state_q, state_d;
  fb_addr_t           cnt_q, cnt_d, out_addr_q, out_addr_d;
  logic [COLOR_W-1:0] bg_q, bg_d, out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d, out_clear_q, out_clear_d;
  logic               clear_done_q, clear_done_d, overflow_q, overflow_d, clipped_q, clipped_d;

  pixel_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wdata   ({pix_addr, color_in}),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    in_range     = (x_in < 9'(SCREEN_W)) && (y_in < 8'(SCREEN_H));
    pix_addr     = fb_addr(x_in, y_in);
    accept       = draw && !fifo_full && in_range;
    hs           = out_valid_q && wr_ready;
    load         = !out_valid_q || wr_ready;
    state_d      = state_q;
    cnt_d        = cnt_q;
    bg_d         = bg_q;
    out_valid_d  = out_valid_q;
    out_clear_d  = out_clear_q;
    out_addr_d   = out_addr_q;
    out_data_d   = out_data_q;
    clear_done_d = 1'b0;
    overflow_d   = overflow_q | (draw && fifo_full);
    clipped_d    = clipped_q | (draw && !in_range);
    bypass       = 1'b0;
    fifo_pop     = 1'b0;
    if (load) begin
      out_valid_d = 1'b0;
      out_clear_d = 1'b0;
    end
    case (state_q)
      ST_RUN: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
          bg_d    = bg_color;
          cnt_d   = '0;
        end else if (load) begin
          // FIFO head has priority; an empty FIFO lets the incoming pixel go straight out
          if (!fifo_empty) begin
            fifo_pop                 = 1'b1;
            out_valid_d              = 1'b1;
            {out_addr_d, out_data_d} = fifo_rdata;
          end else if (accept) begin
            bypass      = 1'b1;
            out_valid_d = 1'b1;
            out_addr_d  = pix_addr;
            out_data_d  = color_in;
          end
        end
      end
      ST_CLEAR: begin
        // cnt counts clear writes issued; the last one is recognised on its own handshake
        if (load && cnt_q != FB_ADDR_W'(FB_WORDS)) begin
          out_valid_d = 1'b1;
          out_clear_d = 1'b1;
          out_addr_d  = cnt_q;
          out_data_d  = bg_q;
          cnt_d       = cnt_q + 1'b1;
        end
        if (hs && out_clear_q && out_addr_q == FB_ADDR_W'(FB_WORDS - 1)) begin
          clear_done_d = 1'b1;
          state_d      = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    fifo_push = accept && !bypass;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      bg_q         <= '0;
      out_valid_q  <= 1'b0;
      out_clear_q  <= 1'b0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      clear_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      clipped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bg_q         <= bg_d;
      out_valid_q  <= out_valid_d;
      out_clear_q  <= out_clear_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      clear_done_q <= clear_done_d;
      overflow_q   <= overflow_d;
      clipped_q    <= clipped_d;
    end
  end

  assign in_ready   = !fifo_full;
  assign busy       = !fifo_empty || (state_q == ST_CLEAR) || out_valid_q;
  assign clear_done = clear_done_q;
  assign overflow   = overflow_q;
  assign clipped    = clipped_q;
  assign wr_valid   = out_valid_q;
  assign wr_addr    = out_addr_q;
  assign wr_data    = out_data_q;
endmodule
